// File: rtl/ac97_cmd_sched.sv
// AC'97 command-slot scheduler: codec init sequence, periodic power-status
// polling and round-robin host register access, one command per frame.
module ac97_cmd_sched #(
  parameter int          POLL_FRAMES = 4800,
  parameter int          RD_TIMEOUT  = 4,
  parameter logic [15:0] HP_VOL      = 16'h1717
) (
  input  logic        ac97_bitclk,
  input  logic        rst,
  input  logic        ac97_strobe,
  input  logic [19:0] ac97_in_slot1,
  input  logic [19:0] ac97_in_slot2,
  input  logic        ac97_in_slot1_valid,
  input  logic        ac97_in_slot2_valid,
  output logic [19:0] ac97_out_slot1,
  output logic [19:0] ac97_out_slot2,
  output logic        ac97_out_slot1_valid,
  output logic        ac97_out_slot2_valid,
  input  logic        host_req,
  input  logic        host_wr,
  input  logic [6:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic        host_rvalid,
  output logic [15:0] host_rdata,
  output logic        host_rerr,
  output logic        init_done,
  output logic        busy,
  output logic [15:0] pwr_status,
  output logic        pwr_ready
);

  localparam int PW = (POLL_FRAMES > 1) ? $clog2(POLL_FRAMES) : 1;
  localparam int TW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [6:0] PWR_ADDR = 7'h26;

  typedef enum logic [2:0] {INIT0, INIT1, INIT2, INIT3, IDLE, WR, RD_WAIT} state_t;

  state_t        state_reg, state_next;
  logic [19:0]   slot1_reg, slot1_next, slot2_reg, slot2_next;
  logic          valid_reg, valid_next;
  logic          ack_reg, ack_next, rvalid_reg, rvalid_next, rerr_reg, rerr_next;
  logic [15:0]   rdata_reg, rdata_next, pwr_reg, pwr_next;
  logic          init_done_reg, init_done_next;
  logic [PW-1:0] poll_cnt_reg, poll_cnt_next;
  logic          poll_pend_reg, poll_pend_next;
  logic          last_host_reg, last_host_next;
  logic          cmd_host_reg, cmd_host_next;
  logic [6:0]    cmd_addr_reg, cmd_addr_next;
  logic [TW-1:0] to_cnt_reg, to_cnt_next;

  logic          grant_host, rd_match, poll_wrap, poll_clear;
  logic          unused_in;

  assign unused_in = ^{ac97_in_slot1[19], ac97_in_slot1[11:0], ac97_in_slot2[3:0]};

  assign rd_match = ac97_in_slot1_valid && ac97_in_slot2_valid &&
                    (ac97_in_slot1[18:12] == cmd_addr_reg);
  // Host wins unless a poll is pending and the host was served last.
  assign grant_host = host_req && init_done_reg && (!poll_pend_reg || !last_host_reg);

  always_comb begin
    state_next     = state_reg;
    slot1_next     = slot1_reg;
    slot2_next     = slot2_reg;
    valid_next     = valid_reg;
    ack_next       = 1'b0;
    rvalid_next    = 1'b0;
    rdata_next     = rdata_reg;
    rerr_next      = rerr_reg;
    pwr_next       = pwr_reg;
    init_done_next = init_done_reg;
    poll_cnt_next  = poll_cnt_reg;
    poll_pend_next = poll_pend_reg;
    last_host_next = last_host_reg;
    cmd_host_next  = cmd_host_reg;
    cmd_addr_next  = cmd_addr_reg;
    to_cnt_next    = to_cnt_reg;
    poll_wrap      = 1'b0;
    poll_clear     = 1'b0;
    if (ac97_strobe) begin
      slot1_next = 20'h0;
      slot2_next = 20'h0;
      valid_next = 1'b0;
      if (init_done_reg) begin
        if (poll_cnt_reg == PW'(POLL_FRAMES - 1)) begin
          poll_cnt_next = '0;
          poll_wrap     = 1'b1;
        end else begin
          poll_cnt_next = poll_cnt_reg + 1'b1;
        end
      end
      case (state_reg)
        INIT0: begin
          slot1_next = {1'b0, 7'h00, 12'h0};
          valid_next = 1'b1;
          state_next = INIT1;
        end
        INIT1: begin
          slot1_next = {1'b0, 7'h02, 12'h0};
          valid_next = 1'b1;
          state_next = INIT2;
        end
        INIT2: begin
          slot1_next = {1'b0, 7'h04, 12'h0};
          slot2_next = {HP_VOL, 4'h0};
          valid_next = 1'b1;
          state_next = INIT3;
        end
        INIT3: begin
          slot1_next     = {1'b0, 7'h18, 12'h0};
          slot2_next     = {16'h0808, 4'h0};
          valid_next     = 1'b1;
          init_done_next = 1'b1;
          state_next     = IDLE;
        end
        IDLE: begin
          to_cnt_next = '0;
          if (grant_host) begin
            ack_next       = 1'b1;
            last_host_next = 1'b1;
            cmd_host_next  = 1'b1;
            cmd_addr_next  = host_addr;
            slot1_next     = {!host_wr, host_addr, 12'h0};
            slot2_next     = host_wr ? {host_wdata, 4'h0} : 20'h0;
            valid_next     = 1'b1;
            state_next     = host_wr ? WR : RD_WAIT;
          end else if (poll_pend_reg) begin
            last_host_next = 1'b0;
            cmd_host_next  = 1'b0;
            cmd_addr_next  = PWR_ADDR;
            slot1_next     = {1'b1, PWR_ADDR, 12'h0};
            valid_next     = 1'b1;
            state_next     = RD_WAIT;
          end
        end
        WR: state_next = IDLE;
        RD_WAIT: begin
          if (rd_match || (to_cnt_reg == TW'(RD_TIMEOUT - 1))) begin
            state_next = IDLE;
            if (cmd_host_reg) begin
              rvalid_next = 1'b1;
              rdata_next  = rd_match ? ac97_in_slot2[19:4] : 16'hFFFF;
              rerr_next   = !rd_match;
            end else begin
              poll_clear = 1'b1;
              if (rd_match) pwr_next = ac97_in_slot2[19:4];
            end
          end else begin
            to_cnt_next = to_cnt_reg + 1'b1;
          end
        end
        default: state_next = INIT0;
      endcase
      // A fresh wrap outranks the completion of the previous poll.
      if (poll_clear) poll_pend_next = 1'b0;
      if (poll_wrap)  poll_pend_next = 1'b1;
    end
  end

  always_ff @(posedge ac97_bitclk) begin
    if (rst) begin
      state_reg     <= INIT0;
      slot1_reg     <= 20'h0;
      slot2_reg     <= 20'h0;
      valid_reg     <= 1'b0;
      ack_reg       <= 1'b0;
      rvalid_reg    <= 1'b0;
      rdata_reg     <= 16'h0;
      rerr_reg      <= 1'b0;
      pwr_reg       <= 16'h0;
      init_done_reg <= 1'b0;
      poll_cnt_reg  <= '0;
      poll_pend_reg <= 1'b0;
      last_host_reg <= 1'b0;
      cmd_host_reg  <= 1'b0;
      cmd_addr_reg  <= 7'h0;
      to_cnt_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      slot1_reg     <= slot1_next;
      slot2_reg     <= slot2_next;
      valid_reg     <= valid_next;
      ack_reg       <= ack_next;
      rvalid_reg    <= rvalid_next;
      rdata_reg     <= rdata_next;
      rerr_reg      <= rerr_next;
      pwr_reg       <= pwr_next;
      init_done_reg <= init_done_next;
      poll_cnt_reg  <= poll_cnt_next;
      poll_pend_reg <= poll_pend_next;
      last_host_reg <= last_host_next;
      cmd_host_reg  <= cmd_host_next;
      cmd_addr_reg  <= cmd_addr_next;
      to_cnt_reg    <= to_cnt_next;
    end
  end

  assign ac97_out_slot1       = slot1_reg;
  assign ac97_out_slot2       = slot2_reg;
  assign ac97_out_slot1_valid = valid_reg;
  assign ac97_out_slot2_valid = valid_reg;
  assign host_ack             = ack_reg;
  assign host_rvalid          = rvalid_reg;
  assign host_rdata           = rdata_reg;
  assign host_rerr            = rerr_reg;
  assign init_done            = init_done_reg;
  assign busy                 = (state_reg != IDLE);
  assign pwr_status           = pwr_reg;
  assign pwr_ready            = &pwr_reg[3:0];

endmodule

// File: tb/tb_ac97_cmd_sched.sv
// Directed bench: instance a (default poll period) covers init, host write/read,
// read timeout and mid-read reset; instance b (8-frame poll) covers arbitration.
module tb_ac97_cmd_sched;
  logic        clk = 1'b0;
  logic        rst_a, rst_b, strobe;
  logic [19:0] in_s1, in_s2;
  logic        in_v1, in_v2;
  logic        req_a, req_b, wr;
  logic [6:0]  addr;
  logic [15:0] wdata;

  logic [19:0] a_s1, a_s2, b_s1, b_s2;
  logic        a_v1, a_v2, b_v1, b_v2;
  logic        a_ack, a_rvalid, a_rerr, a_init, a_busy, a_prdy;
  logic        b_ack, b_rvalid, b_rerr, b_init, b_busy, b_prdy;
  logic [15:0] a_rdata, a_pwr, b_rdata, b_pwr;

  int n_total = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ac97_cmd_sched dut_a (
    .ac97_bitclk(clk), .rst(rst_a), .ac97_strobe(strobe),
    .ac97_in_slot1(in_s1), .ac97_in_slot2(in_s2),
    .ac97_in_slot1_valid(in_v1), .ac97_in_slot2_valid(in_v2),
    .ac97_out_slot1(a_s1), .ac97_out_slot2(a_s2),
    .ac97_out_slot1_valid(a_v1), .ac97_out_slot2_valid(a_v2),
    .host_req(req_a), .host_wr(wr), .host_addr(addr), .host_wdata(wdata),
    .host_ack(a_ack), .host_rvalid(a_rvalid), .host_rdata(a_rdata), .host_rerr(a_rerr),
    .init_done(a_init), .busy(a_busy), .pwr_status(a_pwr), .pwr_ready(a_prdy)
  );

  ac97_cmd_sched #(.POLL_FRAMES(8)) dut_b (
    .ac97_bitclk(clk), .rst(rst_b), .ac97_strobe(strobe),
    .ac97_in_slot1(in_s1), .ac97_in_slot2(in_s2),
    .ac97_in_slot1_valid(in_v1), .ac97_in_slot2_valid(in_v2),
    .ac97_out_slot1(b_s1), .ac97_out_slot2(b_s2),
    .ac97_out_slot1_valid(b_v1), .ac97_out_slot2_valid(b_v2),
    .host_req(req_b), .host_wr(wr), .host_addr(addr), .host_wdata(wdata),
    .host_ack(b_ack), .host_rvalid(b_rvalid), .host_rdata(b_rdata), .host_rerr(b_rerr),
    .init_done(b_init), .busy(b_busy), .pwr_status(b_pwr), .pwr_ready(b_prdy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // One frame: idle cycles, then a one-cycle strobe; returns at the negedge after it.
  task automatic frame();
    repeat (4) @(negedge clk);
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
  endtask

  task automatic codec(input logic [19:0] s1, input logic [19:0] s2, input logic v1, input logic v2);
    in_s1 = s1; in_s2 = s2; in_v1 = v1; in_v2 = v2;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; strobe = 1'b0;
    req_a = 1'b0; req_b = 1'b0; wr = 1'b0; addr = 7'h0; wdata = 16'h0;
    codec(20'h0, 20'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    frame();
    check("rst_valid", a_v1, 1'b0);
    check("rst_slot1", a_s1, 20'h0);
    check("rst_init_done", a_init, 1'b0);
    check("rst_busy", a_busy, 1'b1);
    check("rst_pwr", a_pwr, 16'h0);
    check("rst_ack", a_ack, 1'b0);
    rst_a = 1'b0;

    // Init sequence; a host request raised early must not be acked.
    req_a = 1'b1; wr = 1'b1; addr = 7'h05; wdata = 16'h1111;
    frame();
    check("init0_slot1", a_s1, 20'h00000);
    check("init0_slot2", a_s2, 20'h00000);
    check("init0_valids", {a_v1, a_v2}, 2'b11);
    check("init0_ack", a_ack, 1'b0);
    check("init0_done", a_init, 1'b0);
    frame();
    check("init1_slot1", a_s1, 20'h02000);
    check("init1_ack", a_ack, 1'b0);
    frame();
    check("init2_slot1", a_s1, 20'h04000);
    check("init2_slot2", a_s2, 20'h17170);
    check("init2_ack", a_ack, 1'b0);
    req_a = 1'b0;
    frame();
    check("init3_slot1", a_s1, 20'h18000);
    check("init3_slot2", a_s2, 20'h08080);
    check("init3_done", a_init, 1'b1);
    check("init3_busy", a_busy, 1'b0);
    frame();
    check("idle_valids", {a_v1, a_v2}, 2'b00);
    check("idle_slot1", a_s1, 20'h0);

    // Host write 0x02 <- 0x8000
    req_a = 1'b1; wr = 1'b1; addr = 7'h02; wdata = 16'h8000;
    frame();
    check("wr_ack", a_ack, 1'b1);
    check("wr_slot1", a_s1, 20'h02000);
    check("wr_slot2", a_s2, 20'h80000);
    check("wr_valids", {a_v1, a_v2}, 2'b11);
    check("wr_busy", a_busy, 1'b1);
    @(negedge clk);
    check("wr_ack_pulse", a_ack, 1'b0);
    req_a = 1'b0;
    frame();
    check("wr_done_valids", {a_v1, a_v2}, 2'b00);
    check("wr_done_busy", a_busy, 1'b0);
    check("wr_no_rvalid", a_rvalid, 1'b0);

    // Host read 0x7C answered next frame
    req_a = 1'b1; wr = 1'b0; addr = 7'h7C;
    frame();
    check("rd_ack", a_ack, 1'b1);
    check("rd_slot1", a_s1, 20'hFC000);
    check("rd_slot2", a_s2, 20'h00000);
    check("rd_valids", {a_v1, a_v2}, 2'b11);
    @(negedge clk);
    req_a = 1'b0;
    codec(20'h7C000, 20'h53440, 1'b1, 1'b1);
    frame();
    check("rd_rvalid", a_rvalid, 1'b1);
    check("rd_rdata", a_rdata, 16'h5344);
    check("rd_rerr", a_rerr, 1'b0);
    check("rd_busy", a_busy, 1'b0);
    check("rd_valids_off", a_v1, 1'b0);
    @(negedge clk);
    check("rd_rvalid_pulse", a_rvalid, 1'b0);

    // Host read 0x10 never answered (wrong address, then half-tagged replies)
    req_a = 1'b1; wr = 1'b0; addr = 7'h10;
    codec(20'h0, 20'h0, 1'b0, 1'b0);
    frame();
    check("to_ack", a_ack, 1'b1);
    @(negedge clk);
    req_a = 1'b0;
    for (int f = 1; f <= 3; f++) begin
      if (f < 3) codec(20'h7C000, 20'h12340, 1'b1, 1'b1);
      else       codec(20'h10000, 20'h12340, 1'b1, 1'b0);
      frame();
      check($sformatf("to_wait%0d_rvalid", f), a_rvalid, 1'b0);
      check($sformatf("to_wait%0d_busy", f), a_busy, 1'b1);
    end
    frame();
    check("to_rvalid", a_rvalid, 1'b1);
    check("to_rdata", a_rdata, 16'hFFFF);
    check("to_rerr", a_rerr, 1'b1);
    check("to_busy", a_busy, 1'b0);
    codec(20'h0, 20'h0, 1'b0, 1'b0);

    // Reset while waiting for a read response
    req_a = 1'b1; wr = 1'b0; addr = 7'h20;
    frame();
    check("mr_ack", a_ack, 1'b1);
    @(negedge clk);
    req_a = 1'b0;
    frame();
    check("mr_busy", a_busy, 1'b1);
    rst_a = 1'b1;
    @(negedge clk);
    check("mr_valids", {a_v1, a_v2}, 2'b00);
    check("mr_slots", {a_s1, a_s2}, 40'h0);
    check("mr_rdata", a_rdata, 16'h0);
    check("mr_rerr", a_rerr, 1'b0);
    check("mr_rvalid", a_rvalid, 1'b0);
    check("mr_init_done", a_init, 1'b0);
    check("mr_busy_rst", a_busy, 1'b1);
    rst_a = 1'b0;
    frame();
    check("mr_init0_slot1", a_s1, 20'h00000);
    check("mr_init0_valid", a_v1, 1'b1);
    check("mr_init0_rvalid", a_rvalid, 1'b0);
    frame();
    check("mr_init1_slot1", a_s1, 20'h02000);
    check("mr_init1_rvalid", a_rvalid, 1'b0);

    // Arbitration on instance b with host_req held high throughout
    wr = 1'b1; addr = 7'h04; wdata = 16'h1234; req_b = 1'b1;
    rst_b = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      frame();
      check($sformatf("arb_s%0d_ack", n), b_ack, (n >= 5 && n % 2 == 1) ? 1'b1 : 1'b0);
    end
    check("arb_init_done", b_init, 1'b1);
    frame();
    check("arb_poll_ack", b_ack, 1'b0);
    check("arb_poll_slot1", b_s1, 20'hA6000);
    check("arb_poll_slot2", b_s2, 20'h00000);
    check("arb_poll_busy", b_busy, 1'b1);
    codec(20'h26000, 20'h000F0, 1'b1, 1'b1);
    frame();
    check("arb_pwr_status", b_pwr, 16'h000F);
    check("arb_pwr_ready", b_prdy, 1'b1);
    check("arb_poll_done", b_busy, 1'b0);
    codec(20'h0, 20'h0, 1'b0, 1'b0);
    frame();
    check("arb_host_again", b_ack, 1'b1);
    check("arb_host_slot1", b_s1, 20'h04000);
    check("arb_host_slot2", b_s2, 20'h12340);
    req_b = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
